// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group width,
// derived geometry helpers and the per-stage control payload.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  function automatic int unsigned ngroup(input int unsigned width);
    return width / GROUP_W;
  endfunction

  function automatic int unsigned nstage(input int unsigned width, input int unsigned gps);
    return ngroup(width) / gps;
  endfunction

  // Control part of a stage bundle; operand remainder and partial sum are
  // width-dependent and are appended by the top level.
  typedef struct packed {
    logic valid;
    logic carry;
    logic p;
    logic g;
    logic ovf;
  } stage_ctrl_t;

endpackage

// File: rtl/cla_group.sv
// Combinational 4-bit carry-lookahead group with group propagate/generate.
module cla_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               c_i,
  output logic [GROUP_W-1:0] s_o,
  output logic               p_o,
  output logic               g_o,
  output logic               c_o
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] t;
  logic [GROUP_W-1:0] c;

  // Inclusive propagate (a|b) doubles as the word-propagate term.
  assign g = a_i & b_i;
  assign t = a_i | b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (t[0] & c_i);
  assign c[2] = g[1] | (t[1] & g[0]) | (t[1] & t[0] & c_i);
  assign c[3] = g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0]) | (t[2] & t[1] & t[0] & c_i);

  assign p_o = &t;
  assign g_o = g[3] | (t[3] & g[2]) | (t[3] & t[2] & g[1]) | (t[3] & t[2] & t[1] & g[0]);
  assign c_o = g_o | (p_o & c_i);
  assign s_o = a_i ^ b_i ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves
// GROUPS_PER_STAGE 4-bit groups, with valid/ready flow control and global stall.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             p_out,
  output logic             g_out
);

  localparam int unsigned NSTAGE  = nstage(WIDTH, GROUPS_PER_STAGE);
  localparam int unsigned SLICE_W = GROUP_W * GROUPS_PER_STAGE;

  // Operand remainders shift down so each stage always reads the low slice;
  // finished sum slices enter at the top and shift down into place.
  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t stage_q [NSTAGE];
  stage_t stage_d [NSTAGE];
  logic   stall;

  assign stall    = stage_q[NSTAGE-1].ctrl.valid & ~out_ready;
  assign in_ready = ~stall & rst_n;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    stage_t             src;
    stage_t             nxt;
    logic [SLICE_W-1:0] s_slice;

    if (k == 0) begin : g_src_in
      always_comb begin
        src            = '0;
        src.ctrl.valid = in_valid;
        src.ctrl.carry = sub | cin;
        src.ctrl.p     = 1'b1;
        src.a_rem      = a;
        src.b_rem      = sub ? ~b : b;
      end
    end else begin : g_src_q
      assign src = stage_q[k-1];
    end

    for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_grp
      logic               c_in;
      logic               c_out;
      logic               grp_p;
      logic               grp_g;
      logic               run_p;
      logic               run_g;
      logic [GROUP_W-1:0] s;

      // Group carries and running word P/G chain at group granularity.
      if (j == 0) begin : g_first
        assign c_in  = src.ctrl.carry;
        assign run_p = src.ctrl.p & grp_p;
        assign run_g = grp_g | (grp_p & src.ctrl.g);
      end else begin : g_next
        assign c_in  = g_grp[j-1].c_out;
        assign run_p = g_grp[j-1].run_p & grp_p;
        assign run_g = grp_g | (grp_p & g_grp[j-1].run_g);
      end

      cla_group u_group (
        .a_i (src.a_rem[j*GROUP_W +: GROUP_W]),
        .b_i (src.b_rem[j*GROUP_W +: GROUP_W]),
        .c_i (c_in),
        .s_o (s),
        .p_o (grp_p),
        .g_o (grp_g),
        .c_o (c_out)
      );

      assign s_slice[j*GROUP_W +: GROUP_W] = s;
    end

    always_comb begin
      nxt            = '0;
      nxt.ctrl.valid = src.ctrl.valid;
      nxt.ctrl.carry = g_grp[GROUPS_PER_STAGE-1].c_out;
      nxt.ctrl.p     = g_grp[GROUPS_PER_STAGE-1].run_p;
      nxt.ctrl.g     = g_grp[GROUPS_PER_STAGE-1].run_g;
      // Carry into the MSB is recovered from the MSB sum bit.
      if (k == NSTAGE - 1) begin
        nxt.ctrl.ovf = src.a_rem[SLICE_W-1] ^ src.b_rem[SLICE_W-1]
                     ^ s_slice[SLICE_W-1] ^ g_grp[GROUPS_PER_STAGE-1].c_out;
      end
      nxt.a_rem = src.a_rem >> SLICE_W;
      nxt.b_rem = src.b_rem >> SLICE_W;
      nxt.sum   = (src.sum >> SLICE_W) | (WIDTH'(s_slice) << (WIDTH - SLICE_W));
    end

    assign stage_d[k] = nxt;
  end

  // All stages advance together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        stage_q[k] <= '0;
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[NSTAGE-1].ctrl.valid;
  assign sum       = stage_q[NSTAGE-1].sum;
  assign cout      = stage_q[NSTAGE-1].ctrl.carry;
  assign ovf       = stage_q[NSTAGE-1].ctrl.ovf;
  assign p_out     = stage_q[NSTAGE-1].ctrl.p;
  assign g_out     = stage_q[NSTAGE-1].ctrl.g;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three configurations driven in lockstep and
// scored against an arithmetic reference model with per-instance queues.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [31:0] a_bus;
  logic [31:0] b_bus;
  logic [2:0]  in_rdy;
  logic [2:0]  out_vld;
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [2:0]  p_v;
  logic [2:0]  g_v;
  logic [15:0] sum0;
  logic [15:0] sum1;
  logic [31:0] sum2;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(16), .GROUPS_PER_STAGE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin), .sub(sub),
    .out_valid(out_vld[0]), .out_ready(out_ready), .sum(sum0), .cout(cout_v[0]),
    .ovf(ovf_v[0]), .p_out(p_v[0]), .g_out(g_v[0]));

  cla_pipe_adder #(.WIDTH(16), .GROUPS_PER_STAGE(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin), .sub(sub),
    .out_valid(out_vld[1]), .out_ready(out_ready), .sum(sum1), .cout(cout_v[1]),
    .ovf(ovf_v[1]), .p_out(p_v[1]), .g_out(g_v[1]));

  cla_pipe_adder #(.WIDTH(32), .GROUPS_PER_STAGE(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .a(a_bus), .b(b_bus), .cin(cin), .sub(sub),
    .out_valid(out_vld[2]), .out_ready(out_ready), .sum(sum2), .cout(cout_v[2]),
    .ovf(ovf_v[2]), .p_out(p_v[2]), .g_out(g_v[2]));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        p;
    logic        g;
    int          stamp;
  } exp_t;

  exp_t        sb [3][$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  bit          lat_chk = 1'b0;
  bit          stl_prev [3];
  logic [36:0] pout [3];

  function automatic int width_of(input int d);
    return (d == 2) ? 32 : 16;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic logic [31:0] sum_of(input int d);
    case (d)
      0:       return 32'(sum0);
      1:       return 32'(sum1);
      default: return sum2;
    endcase
  endfunction

  function automatic logic [36:0] outs(input int d);
    return {out_vld[d], sum_of(d), cout_v[d], ovf_v[d], p_v[d], g_v[d]};
  endfunction

  // Reference: plain modular arithmetic on a wide integer.
  function automatic exp_t model(input int d, input logic [31:0] ta, input logic [31:0] tb,
                                 input logic tc, input logic ts);
    exp_t            e;
    int              w;
    longint unsigned mask, av, bv, full;
    w      = width_of(d);
    mask   = (64'd1 << w) - 64'd1;
    av     = 64'(ta) & mask;
    bv     = 64'(ts ? ~tb : tb) & mask;
    full   = av + bv + 64'(ts ? 1'b1 : tc);
    e.sum  = 32'(full & mask);
    e.cout = ((full >> w) & 64'd1) != 64'd0;
    e.ovf  = (((av >> (w-1)) & 64'd1) == ((bv >> (w-1)) & 64'd1)) &&
             (((full >> (w-1)) & 64'd1) != ((av >> (w-1)) & 64'd1));
    e.p    = (av | bv) == mask;
    e.g    = ((av + bv) >> w) != 64'd0;
    e.stamp = 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit all_empty();
    return (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0);
  endfunction

  // One cycle: drive at the falling edge, then score handshakes before the rising edge.
  task automatic step(input logic rst, input logic iv, input logic [31:0] ta,
                      input logic [31:0] tb, input logic tc, input logic ts, input logic tr);
    exp_t e;
    @(negedge clk);
    rst_n = rst; in_valid = iv; a_bus = ta; b_bus = tb; cin = tc; sub = ts; out_ready = tr;
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (stl_prev[d]) check($sformatf("d%0d_hold", d), 64'(outs(d)), 64'(pout[d]));
      check($sformatf("d%0d_in_ready", d), 64'(in_rdy[d]),
            64'(rst ? !(out_vld[d] && !out_ready) : 1'b0));
      if (out_vld[d] && out_ready) begin
        if (sb[d].size() == 0) begin
          check($sformatf("d%0d_spurious", d), 64'd1, 64'd0);
        end else begin
          e = sb[d].pop_front();
          check($sformatf("d%0d_sum", d), 64'(sum_of(d)), 64'(e.sum));
          check($sformatf("d%0d_cout", d), 64'(cout_v[d]), 64'(e.cout));
          check($sformatf("d%0d_ovf", d), 64'(ovf_v[d]), 64'(e.ovf));
          check($sformatf("d%0d_p", d), 64'(p_v[d]), 64'(e.p));
          check($sformatf("d%0d_g", d), 64'(g_v[d]), 64'(e.g));
          if (lat_chk) check($sformatf("d%0d_latency", d), 64'(cyc - e.stamp), 64'(lat_of(d)));
        end
      end
      if (iv && in_rdy[d]) begin
        e = model(d, ta, tb, tc, ts);
        e.stamp = cyc;
        sb[d].push_back(e);
      end
      stl_prev[d] = rst && out_vld[d] && !out_ready;
      pout[d]     = outs(d);
      if (!rst) sb[d].delete();
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && !all_empty(); i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check(tag, 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'd0);
  endtask

  task automatic directed(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                          input logic ts);
    lat_chk = 1'b1;
    step(1'b1, 1'b1, ta, tb, tc, ts, 1'b1);
    drain("directed_drain");
    lat_chk = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    a_bus = '0; b_bus = '0;
    for (int d = 0; d < 3; d++) begin
      stl_prev[d] = 1'b0;
      pout[d] = '0;
    end

    // Reset state
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < 3; d++) check($sformatf("d%0d_reset_outs", d), 64'(outs(d)), 64'd0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("in_ready_after_reset", 64'(in_rdy), 64'h7);

    // Boundary vectors, each at the configured latency
    directed(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    directed(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);
    directed(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    directed(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    directed(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    directed(32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1);

    // Back-to-back stream with a two-cycle consumer stall
    step(1'b1, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("stall_in_ready", 64'(in_rdy[0]), 64'd0);
      check("stall_valid", 64'(out_vld[0]), 64'd1);
      check("stall_sum", 64'(sum0), 64'h2);
    end
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("stream_sum0", 64'(sum0), 64'h2);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("stream_sum1", 64'(sum0), 64'h4);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("stream_sum2", 64'(sum0), 64'h6);
    drain("stream_drain");

    // Mid-flight reset discards accepted bundles
    step(1'b1, 1'b1, 32'h0000_0111, 32'h0000_0222, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0333, 32'h0000_0444, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("post_reset_valid", 64'(out_vld), 64'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    directed(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);

    // Random traffic at full throughput, then with random backpressure
    lat_chk = 1'b1;
    for (int i = 0; i < 150; i++)
      step(1'b1, 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    drain("random_fast_drain");
    lat_chk = 1'b0;
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    drain("random_stall_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
